// File: rtl/tdpram_be_v.sv
// True dual-port RAM with per-byte write enables, selectable same-port
// read-during-write behaviour, optional output register and a post-reset
// zero-fill sequencer. Handshake: an access is taken on any cycle where
// enp_i=1 and busy_o=0; its result appears exactly 1 (OUT_REG=0) or 2
// (OUT_REG=1) cycles later, marked by a one-cycle validp_o pulse. There is
// no back-pressure.
module tdpram_be_v #(
   parameter int AWIDTH         = 8,
   parameter int DWIDTH         = 32,
   parameter int DEPTH          = 0,
   parameter int RDW_MODE       = 0,
   parameter int OUT_REG        = 0,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  en1_i,
   input  logic [DWIDTH/8-1:0]   wen1_i,
   input  logic [AWIDTH-1:0]     addr1_i,
   input  logic [DWIDTH-1:0]     data1_i,
   output logic [DWIDTH-1:0]     data1_o,
   output logic                  valid1_o,
   input  logic                  en2_i,
   input  logic [DWIDTH/8-1:0]   wen2_i,
   input  logic [AWIDTH-1:0]     addr2_i,
   input  logic [DWIDTH-1:0]     data2_i,
   output logic [DWIDTH-1:0]     data2_o,
   output logic                  valid2_o,
   output logic                  busy_o,
   output logic                  collision_o,
   output logic                  oor_o
);

   localparam int NB   = DWIDTH / 8;
   localparam int SIZE = (DEPTH == 0) ? (1 << AWIDTH) : DEPTH;
   localparam int IW   = (SIZE > 1) ? $clog2(SIZE) : 1;
   localparam int CW   = $clog2(SIZE) + 1;
   localparam logic [AWIDTH:0] SIZE_A = (AWIDTH + 1)'(SIZE);
   localparam logic [CW-1:0]   LAST   = CW'(SIZE - 1);

   typedef enum logic {ST_CLEAR, ST_READY} state_t;

   state_t            state;
   logic [CW-1:0]     clr_cnt;
   logic [DWIDTH-1:0] mem [SIZE];

   logic              act1, act2, in1, in2, wr1, wr2, we1, we2, same_addr;
   logic [IW-1:0]     idx1, idx2;
   logic [DWIDTH-1:0] old1, old2, merged1, merged2;
   logic [DWIDTH-1:0] rd1, rd2;
   logic              rv1, rv2;
   logic [DWIDTH-1:0] q1_data, q2_data;
   logic              q1_valid, q2_valid;

   assign busy_o = (state == ST_CLEAR);

   // Access qualification; nothing is accepted while clearing or in reset.
   assign act1      = en1_i & ~busy_o & rstn_i;
   assign act2      = en2_i & ~busy_o & rstn_i;
   assign in1       = ({1'b0, addr1_i} < SIZE_A);
   assign in2       = ({1'b0, addr2_i} < SIZE_A);
   assign wr1       = |wen1_i;
   assign wr2       = |wen2_i;
   assign we1       = act1 & wr1 & in1;
   assign we2       = act2 & wr2 & in2;
   assign same_addr = (addr1_i == addr2_i);
   assign idx1      = addr1_i[IW-1:0];
   assign idx2      = addr2_i[IW-1:0];
   assign old1      = mem[idx1];
   assign old2      = mem[idx2];

   // Clear sequencer: zero one word per cycle, then hand over to READY.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
         clr_cnt <= '0;
      end else if (state == ST_CLEAR) begin
         if (clr_cnt == LAST) state <= ST_READY;
         else                 clr_cnt <= clr_cnt + CW'(1);
      end
   end

   // Word as it will look after this cycle's writes; port 1 overrides port 2.
   always_comb begin
      merged1 = old1;
      merged2 = old2;
      for (int b = 0; b < NB; b++) begin
         if (we2 && same_addr && wen2_i[b]) merged1[8*b +: 8] = data2_i[8*b +: 8];
         if (wen1_i[b])                     merged1[8*b +: 8] = data1_i[8*b +: 8];
         if (wen2_i[b])                     merged2[8*b +: 8] = data2_i[8*b +: 8];
         if (we1 && same_addr && wen1_i[b]) merged2[8*b +: 8] = data1_i[8*b +: 8];
      end
   end

   // Memory array: clear writes zeros, otherwise port 2 lanes then port 1
   // lanes, so the later assignment gives port 1 priority on a collision.
   always_ff @(posedge clk_i) begin
      if (busy_o && rstn_i) begin
         mem[clr_cnt[IW-1:0]] <= '0;
      end else begin
         for (int b = 0; b < NB; b++)
            if (we2 && wen2_i[b]) mem[idx2][8*b +: 8] <= data2_i[8*b +: 8];
         for (int b = 0; b < NB; b++)
            if (we1 && wen1_i[b]) mem[idx1][8*b +: 8] <= data1_i[8*b +: 8];
      end
   end

   // Per-port result selection, including read-during-write policy.
   always_comb begin
      rd1 = '0;
      rv1 = 1'b0;
      rd2 = '0;
      rv2 = 1'b0;
      if (act1 && !(wr1 && RDW_MODE == 2)) begin
         rv1 = 1'b1;
         if (!in1)                     rd1 = '0;
         else if (wr1 && RDW_MODE == 0) rd1 = merged1;
         else                           rd1 = old1;
      end
      if (act2 && !(wr2 && RDW_MODE == 2)) begin
         rv2 = 1'b1;
         if (!in2)                     rd2 = '0;
         else if (wr2 && RDW_MODE == 0) rd2 = merged2;
         else                           rd2 = old2;
      end
   end

   // First result stage; data only moves when a new result arrives.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         q1_data     <= '0;
         q1_valid    <= 1'b0;
         q2_data     <= '0;
         q2_valid    <= 1'b0;
         collision_o <= 1'b0;
         oor_o       <= 1'b0;
      end else begin
         q1_valid    <= rv1;
         q2_valid    <= rv2;
         if (rv1) q1_data <= rd1;
         if (rv2) q2_data <= rd2;
         collision_o <= we1 & we2 & same_addr;
         oor_o       <= (act1 & ~in1) | (act2 & ~in2);
      end
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         // Optional second stage, same hold-on-idle behaviour as the first.
         always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
               data1_o  <= '0;
               valid1_o <= 1'b0;
               data2_o  <= '0;
               valid2_o <= 1'b0;
            end else begin
               valid1_o <= q1_valid;
               valid2_o <= q2_valid;
               if (q1_valid) data1_o <= q1_data;
               if (q2_valid) data2_o <= q2_data;
            end
         end
      end else begin : g_no_out_reg
         assign data1_o  = q1_data;
         assign valid1_o = q1_valid;
         assign data2_o  = q2_data;
         assign valid2_o = q2_valid;
      end
   endgenerate

endmodule

// File: tb/tb_tdpram_be_v.sv
// Bench for tdpram_be_v: three instances share one stimulus stream
// (u0: write-first, u1: read-first with output register, u2: no-change).
// A behavioural memory model produces expected results into a queue.
module tb_tdpram_be_v;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int SZ = 16;

   typedef struct packed {
      logic [2:0]  id;
      logic [31:0] due;
      logic [31:0] data;
   } exp_t;

   logic          clk, rstn;
   logic          en1, en2;
   logic [3:0]    wen1, wen2;
   logic [AW-1:0] addr1, addr2;
   logic [DW-1:0] din1, din2;
   logic [DW-1:0] d1 [3];
   logic [DW-1:0] d2 [3];
   logic          v1 [3];
   logic          v2 [3];
   logic          busy [3];
   logic          col [3];
   logic          oor [3];

   exp_t          exp_q[$];
   logic [31:0]   mem_m [SZ];
   logic [31:0]   last_d [6];
   int            n_checks, n_pass, cyc;
   logic          ready_m;

   genvar g;
   generate
      for (g = 0; g < 3; g++) begin : g_dut
         tdpram_be_v #(
            .AWIDTH(AW), .DWIDTH(DW), .DEPTH(SZ), .RDW_MODE(g),
            .OUT_REG((g == 1) ? 1 : 0), .CLEAR_ON_RESET(1)
         ) u_dut (
            .clk_i(clk), .rstn_i(rstn),
            .en1_i(en1), .wen1_i(wen1), .addr1_i(addr1), .data1_i(din1),
            .data1_o(d1[g]), .valid1_o(v1[g]),
            .en2_i(en2), .wen2_i(wen2), .addr2_i(addr2), .data2_i(din2),
            .data2_o(d2[g]), .valid2_o(v2[g]),
            .busy_o(busy[g]), .collision_o(col[g]), .oor_o(oor[g])
         );
      end
   endgenerate

   // clock / watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
      else             n_pass++;
   endtask

   function automatic logic [31:0] lane_mix(input logic [31:0] base, input logic [31:0] d,
                                            input logic [3:0] w);
      logic [31:0] r;
      r = base;
      for (int b = 0; b < 4; b++) if (w[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   // scoreboard: compare valid every cycle, pop data when due, else data must hold
   task automatic check_outputs();
      for (int gi = 0; gi < 3; gi++) begin
         for (int p = 0; p < 2; p++) begin
            int          id, idx;
            logic        got_v, exp_v;
            logic [31:0] got_d;
            id    = gi * 2 + p;
            idx   = -1;
            got_v = (p == 0) ? v1[gi] : v2[gi];
            got_d = (p == 0) ? d1[gi] : d2[gi];
            for (int i = 0; i < exp_q.size(); i++)
               if (int'(exp_q[i].id) == id) begin idx = i; break; end
            exp_v = (idx >= 0) && (exp_q[idx].due == 32'(cyc));
            check_eq($sformatf("valid_u%0d_p%0d_c%0d", gi, p + 1, cyc), 32'(got_v), 32'(exp_v));
            if (exp_v) begin
               check_eq($sformatf("data_u%0d_p%0d_c%0d", gi, p + 1, cyc), got_d, exp_q[idx].data);
               last_d[id] = exp_q[idx].data;
               exp_q.delete(idx);
            end else begin
               check_eq($sformatf("hold_u%0d_p%0d_c%0d", gi, p + 1, cyc), got_d, last_d[id]);
            end
         end
      end
   endtask

   // driver: one access per port per cycle, model computes expectations
   task automatic step(input logic e1, input logic [3:0] w1, input logic [AW-1:0] a1,
                       input logic [31:0] dd1, input logic e2, input logic [3:0] w2,
                       input logic [AW-1:0] a2, input logic [31:0] dd2);
      logic        i1, i2, r1, r2, we1, we2, col_e, oor_e;
      logic [31:0] old1, old2, fin1, fin2;
      exp_t        e;
      i1   = (a1 < AW'(SZ));
      i2   = (a2 < AW'(SZ));
      r1   = (w1 != 4'd0);
      r2   = (w2 != 4'd0);
      we1  = e1 && r1 && i1;
      we2  = e2 && r2 && i2;
      old1 = i1 ? mem_m[a1[3:0]] : 32'd0;
      old2 = i2 ? mem_m[a2[3:0]] : 32'd0;
      fin1 = old1;
      if (we2 && a2 == a1) fin1 = lane_mix(fin1, dd2, w2);
      if (we1)             fin1 = lane_mix(fin1, dd1, w1);
      fin2 = old2;
      if (we2)             fin2 = lane_mix(fin2, dd2, w2);
      if (we1 && a1 == a2) fin2 = lane_mix(fin2, dd1, w1);
      for (int gi = 0; gi < 3; gi++) begin
         e.due = 32'(cyc + ((gi == 1) ? 2 : 1));
         if (e1 && !(r1 && gi == 2)) begin
            e.id   = 3'(gi * 2);
            e.data = !i1 ? 32'd0 : (r1 && gi == 0) ? fin1 : old1;
            exp_q.push_back(e);
         end
         if (e2 && !(r2 && gi == 2)) begin
            e.id   = 3'(gi * 2 + 1);
            e.data = !i2 ? 32'd0 : (r2 && gi == 0) ? fin2 : old2;
            exp_q.push_back(e);
         end
      end
      col_e = we1 && we2 && (a1 == a2);
      oor_e = (e1 && !i1) || (e2 && !i2);
      if (we2) mem_m[a2[3:0]] = lane_mix(mem_m[a2[3:0]], dd2, w2);
      if (we1) mem_m[a1[3:0]] = lane_mix(mem_m[a1[3:0]], dd1, w1);
      en1 = e1; wen1 = w1; addr1 = a1; din1 = dd1;
      en2 = e2; wen2 = w2; addr2 = a2; din2 = dd2;
      @(posedge clk);
      #1;
      cyc++;
      check_outputs();
      for (int gi = 0; gi < 3; gi++) begin
         check_eq($sformatf("collision_u%0d_c%0d", gi, cyc), 32'(col[gi]), 32'(col_e));
         check_eq($sformatf("oor_u%0d_c%0d", gi, cyc), 32'(oor[gi]), 32'(oor_e));
         if (ready_m) check_eq($sformatf("busy_u%0d_c%0d", gi, cyc), 32'(busy[gi]), 32'd0);
      end
   endtask

   task automatic idle();
      step(1'b0, 4'd0, '0, '0, 1'b0, 4'd0, '0, '0);
   endtask

   task automatic assert_reset(input string tag);
      rstn = 1'b0;
      en1 = 1'b0; en2 = 1'b0; wen1 = '0; wen2 = '0;
      #1;
      for (int gi = 0; gi < 3; gi++) begin
         check_eq({tag, "_d1"},  d1[gi], 32'd0);
         check_eq({tag, "_d2"},  d2[gi], 32'd0);
         check_eq({tag, "_v1"},  32'(v1[gi]), 32'd0);
         check_eq({tag, "_v2"},  32'(v2[gi]), 32'd0);
         check_eq({tag, "_col"}, 32'(col[gi]), 32'd0);
         check_eq({tag, "_oor"}, 32'(oor[gi]), 32'd0);
         check_eq({tag, "_busy"}, 32'(busy[gi]), 32'd1);
      end
      exp_q.delete();
      for (int i = 0; i < 6; i++) last_d[i] = '0;
      ready_m = 1'b0;
      @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   task automatic wait_clear(input string tag);
      int n;
      n = 0;
      while (busy[0] && n < 64) begin
         n++;
         idle();
      end
      check_eq(tag, 32'(n), 32'(SZ));
      for (int i = 0; i < SZ; i++) mem_m[i] = '0;
      ready_m = 1'b1;
   endtask

   task automatic read_all();
      for (int i = 0; i < SZ; i++)
         step(1'b1, 4'd0, AW'(i), '0, 1'b1, 4'd0, AW'(SZ - 1 - i), '0);
      idle();
      idle();
   endtask

   initial begin
      n_checks = 0; n_pass = 0; cyc = 0; ready_m = 1'b0;
      rstn = 1'b0; en1 = 0; en2 = 0; wen1 = 0; wen2 = 0;
      addr1 = 0; addr2 = 0; din1 = 0; din2 = 0;
      repeat (2) @(posedge clk);

      // reset state and power-on clear
      assert_reset("rst0");
      wait_clear("clear_len0");
      read_all();

      // byte enables
      step(1'b1, 4'hF, 5'd3, 32'hAABBCCDD, 1'b0, 4'd0, '0, '0);
      step(1'b1, 4'b0101, 5'd3, 32'h11223344, 1'b0, 4'd0, '0, '0);
      step(1'b1, 4'd0, 5'd3, '0, 1'b0, 4'd0, '0, '0);
      check_eq("be_read", d1[0], 32'hAA22CC44);
      idle();

      // read-during-write on port 1
      step(1'b1, 4'hF, 5'd5, 32'h1, 1'b0, 4'd0, '0, '0);
      step(1'b1, 4'hF, 5'd5, 32'h2, 1'b0, 4'd0, '0, '0);
      check_eq("rdw_mode0_data", d1[0], 32'h2);
      check_eq("rdw_mode2_valid", 32'(v1[2]), 32'd0);
      idle();
      check_eq("rdw_mode1_data", d1[1], 32'h1);
      idle();

      // write/write collision
      step(1'b1, 4'b0001, 5'd7, 32'h000000FF, 1'b1, 4'b1101, 5'd7, 32'hFFFF0000);
      check_eq("collision_pulse", 32'(col[0]), 32'd1);
      step(1'b1, 4'd0, 5'd7, '0, 1'b0, 4'd0, '0, '0);
      check_eq("collision_word", d1[0], 32'hFFFF00FF);
      idle();

      // out-of-range accesses, including the first illegal address
      step(1'b1, 4'hF, 5'd20, 32'hDEADBEEF, 1'b0, 4'd0, '0, '0);
      step(1'b1, 4'd0, 5'd20, '0, 1'b1, 4'd0, 5'd16, '0);
      check_eq("oor_read", d1[0], 32'd0);
      step(1'b0, 4'd0, '0, '0, 1'b1, 4'hF, 5'd31, 32'h12345678);
      idle();
      read_all();

      // random traffic on both ports
      for (int i = 0; i < 300; i++)
         step(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), AW'($urandom_range(0, 19)), $urandom,
              1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), AW'($urandom_range(0, 19)), $urandom);
      idle();
      idle();
      read_all();

      // reset with results in flight, then reset part way through the clear
      step(1'b1, 4'd0, 5'd1, '0, 1'b1, 4'd0, 5'd2, '0);
      assert_reset("rst_access");
      repeat (5) idle();
      assert_reset("rst_midclear");
      wait_clear("clear_len1");
      read_all();

      idle();
      idle();
      check_eq("sb_drain", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/tdpram_be_v.md
TDPRAM_BE_V -- requirements
Module: tdpram_be_v

Interface
REQ-001 SHALL have parameter AWIDTH, default 8, address width.
REQ-002 SHALL have parameter DWIDTH, default 32, data width; must be a multiple of 8; NB = DWIDTH/8 byte lanes.
REQ-003 SHALL have parameter DEPTH, default 0, word count; 0 means 2^AWIDTH.
REQ-004 SHALL have parameter RDW_MODE, default 0, same-port read-during-write mode: 0 write-first, 1 read-first, 2 no-change.
REQ-005 SHALL have parameter OUT_REG, default 0, extra output pipeline register (0 or 1).
REQ-006 SHALL have parameter CLEAR_ON_RESET, default 1, zero-fill memory after reset.
REQ-007 SHALL have one clock and an asynchronous, active-low reset: clk_i  in  1  clock; rstn_i  in  1  asynchronous active-low reset.
REQ-008 SHALL have, for port p in {1,2}: enp_i  in  1  access enable; wenp_i  in  NB  byte write enables; addrp_i  in  AWIDTH  address; datap_i  in  DWIDTH  write data; datap_o  out  DWIDTH  read data; validp_o  out  1  datap_o holds a new result.
REQ-009 SHALL have busy_o  out  1  clear in progress; accesses ignored.
REQ-010 SHALL have collision_o  out  1  one-cycle pulse on a same-address write/write conflict.
REQ-011 SHALL have oor_o  out  1  one-cycle pulse on an enabled access with address >= SIZE.

Function
REQ-012 SHALL set SIZE = DEPTH, or 2^AWIDTH if DEPTH = 0.
REQ-013 SHALL gate each port's access on enp_i=1 and busy_o=0; a gated-off port leaves memory and datap_o unchanged, and validp_o stays 0.
REQ-014 SHALL update, on an enabled write, only the byte lanes whose wenp_i bit is 1; unselected lanes keep their old value.
REQ-015 SHALL treat an enabled access with wenp_i all zero as a read.
REQ-016 SHALL apply RDW_MODE on a same-port write: datap_o = merged new word (0), old word (1), or unchanged (2).
REQ-017 SHALL assert validp_o for every enabled access, except writes in mode 2.
REQ-018 SHALL give a latency from enable to datap_o/validp_o of 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1); validp_o is a single-cycle pulse per access; pipeline holds one access per cycle, no stalls.
REQ-019 SHALL, on a read on one port and a write on the other to the same address in the same cycle, return the old word to the reader.
REQ-020 SHALL, when both ports write the same address in the same cycle, apply byte lanes enabled on port 1 (port 1 wins), apply lanes enabled only on port 2, and pulse collision_o the next cycle.
REQ-021 SHALL suppress out-of-range writes, return 0 for out-of-range reads (validp_o still asserted), and pulse oor_o the next cycle.
REQ-022 SHALL implement a clear FSM with states CLEAR and READY.
REQ-023 SHALL, after reset release with CLEAR_ON_RESET=1, enter CLEAR, write zero to address 0..SIZE-1 at one word per cycle via an internal counter, and hold busy_o=1 for exactly SIZE cycles.
REQ-024 SHALL go to READY after the counter reaches SIZE-1; busy_o falls in the same edge.
REQ-025 SHALL, with CLEAR_ON_RESET=0, enter READY directly and leave memory contents undefined.
REQ-026 SHALL size the clear counter as clog2(SIZE)+1 bits, with no wrap before termination.

Reset
REQ-027 SHALL, while rstn_i=0, drive data1_o=data2_o=0, valid1_o=valid2_o=0, collision_o=0, oor_o=0, and the pipeline registers to 0.
REQ-028 SHALL drive busy_o=CLEAR_ON_RESET during reset and reset the clear counter to 0.
REQ-029 SHALL, on reset assertion mid-clear or mid-access, abort immediately, drop in-flight results, and restart CLEAR from address 0 on release.
REQ-030 SHALL NOT reset the memory array itself; only the CLEAR FSM zeroes it.

Verification
REQ-031 Clear: SIZE=16, release reset -> busy_o high exactly 16 cycles; then reads of all addresses return 0 with validp_o at latency 1 (OUT_REG=0) or 2 (OUT_REG=1).
REQ-032 Byte enables: write 0xAABBCCDD to addr 3, then wen1_i=4'b0101 with 0x11223344 to addr 3 -> read returns 0xAA22CC44.
REQ-033 Read-during-write modes: addr 5=0x1, port 1 writes 0x2 -> data1_o=0x2 (mode 0), 0x1 (mode 1), unchanged with valid1_o=0 (mode 2).
REQ-034 Write/write collision: port 1 writes 0x000000FF with wen=4'b0001, port 2 writes 0xFFFF0000 with wen=4'b1101, both to addr 7 -> collision_o pulses once; addr 7 reads 0xFFFF00FF.
REQ-035 Out of range: DEPTH=10, write to addr 12 then read addr 12 -> oor_o pulses each access; read returns 0; addresses 0..9 unchanged.
REQ-036 Reset mid-clear: assert rstn_i=0 at clear cycle 5 -> all outputs 0 immediately; after release, busy_o high a full SIZE cycles again.
